// File: rtl/ps2_transmitter.sv
// Purpose: host-to-device PS/2 command transmitter (inhibit, start, 8 data LSB first, odd parity, stop, ACK).
// Latency: INHIBIT_CYCLES of clock inhibit, then 11 device clocks, then bus-idle wait before done_o.
// Backpressure: ready_o low while busy; data_valid_i is ignored (not queued) until ready_o returns high.
// Ports: clk_i/rst_i clock and async active-high reset; ps2_clk_i/ps2_data_i filtered line levels;
//        ps2_clk_oe_o/ps2_data_oe_o active-high pull-low enables; data_i/data_valid_i/ready_o byte handshake;
//        busy_o transaction in progress; done_o end-of-transaction pulse, error_o = NACK or timeout.
module ps2_transmitter #(
    parameter int INHIBIT_CYCLES = 10000,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_oe_o,
    output logic       ps2_data_oe_o,
    input  logic [7:0] data_i,
    input  logic       data_valid_i,
    output logic       ready_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       error_o
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_INHIBIT   = 3'd1;
    localparam logic [2:0] S_START     = 3'd2;
    localparam logic [2:0] S_DATA      = 3'd3;
    localparam logic [2:0] S_PARITY    = 3'd4;
    localparam logic [2:0] S_STOP      = 3'd5;
    localparam logic [2:0] S_WAIT_IDLE = 3'd6;

    localparam int IW = $clog2(INHIBIT_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
    localparam logic [IW-1:0] INH_PRE  = IW'(INHIBIT_CYCLES - 2);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

    logic [2:0]    state;
    logic          prev_clk;
    logic          clk_fall;
    logic [IW-1:0] inh_cnt;
    logic [TW-1:0] to_cnt;
    logic [3:0]    bit_idx;
    logic [7:0]    tx_dat;
    logic          parity;
    logic          ack;

    assign clk_fall = prev_clk & ~ps2_clk_i;

    // The done cycle is already IDLE in state, so masking with done_o keeps
    // ready_o and done_o mutually exclusive and delays ready_o by one cycle.
    assign ready_o = (state == S_IDLE) & ~done_o;
    assign busy_o  = ~ready_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state         <= S_IDLE;
            prev_clk      <= 1'b1;
            inh_cnt       <= '0;
            to_cnt        <= '0;
            bit_idx       <= '0;
            tx_dat        <= '0;
            parity        <= 1'b0;
            ack           <= 1'b0;
            ps2_clk_oe_o  <= 1'b0;
            ps2_data_oe_o <= 1'b0;
            done_o        <= 1'b0;
            error_o       <= 1'b0;
        end else begin
            prev_clk <= ps2_clk_i;
            done_o   <= 1'b0;
            error_o  <= 1'b0;
            case (state)
                S_IDLE: begin
                    ps2_clk_oe_o  <= 1'b0;
                    ps2_data_oe_o <= 1'b0;
                    if (data_valid_i && ready_o) begin
                        tx_dat        <= data_i;
                        parity        <= ~^data_i;
                        inh_cnt       <= '0;
                        ps2_clk_oe_o  <= 1'b1;
                        // A one-cycle inhibit must already carry the start bit.
                        ps2_data_oe_o <= (INHIBIT_CYCLES == 1);
                        state         <= S_INHIBIT;
                    end
                end
                S_INHIBIT: begin
                    if (inh_cnt == INH_LAST) begin
                        ps2_clk_oe_o  <= 1'b0;
                        ps2_data_oe_o <= 1'b1;
                        to_cnt        <= '0;
                        state         <= S_START;
                    end else begin
                        inh_cnt <= inh_cnt + IW'(1);
                        // Start bit goes low on the last inhibit cycle, before clock release.
                        if (INHIBIT_CYCLES >= 2 && inh_cnt == INH_PRE) begin
                            ps2_data_oe_o <= 1'b1;
                        end
                    end
                end
                default: begin
                    // START, DATA, PARITY, STOP, WAIT_IDLE share the edge-driven
                    // bit engine and the inter-edge timeout.
                    if (clk_fall) begin
                        to_cnt <= '0;
                        case (state)
                            S_START: begin
                                ps2_data_oe_o <= ~tx_dat[0];
                                bit_idx       <= 4'd1;
                                state         <= S_DATA;
                            end
                            S_DATA: begin
                                if (bit_idx == 4'd8) begin
                                    ps2_data_oe_o <= ~parity;
                                    state         <= S_PARITY;
                                end else begin
                                    ps2_data_oe_o <= ~tx_dat[bit_idx[2:0]];
                                    bit_idx       <= bit_idx + 4'd1;
                                end
                            end
                            S_PARITY: begin
                                ps2_data_oe_o <= 1'b0;
                                state         <= S_STOP;
                            end
                            S_STOP: begin
                                ack   <= ps2_data_i;
                                state <= S_WAIT_IDLE;
                            end
                            S_WAIT_IDLE: begin
                            end
                            default: begin
                                ps2_clk_oe_o  <= 1'b0;
                                ps2_data_oe_o <= 1'b0;
                                state         <= S_IDLE;
                            end
                        endcase
                    end else if (state == S_WAIT_IDLE && ps2_clk_i && ps2_data_i) begin
                        done_o  <= 1'b1;
                        error_o <= ack;
                        state   <= S_IDLE;
                    end else if (to_cnt == TO_LAST) begin
                        ps2_clk_oe_o  <= 1'b0;
                        ps2_data_oe_o <= 1'b0;
                        done_o        <= 1'b1;
                        error_o       <= 1'b1;
                        state         <= S_IDLE;
                    end else begin
                        to_cnt <= to_cnt + TW'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_transmitter.sv
// Purpose: self-checking bench for ps2_transmitter with a behavioural PS/2 device on open-drain lines.
// Latency: checks inhibit length, frame bits sampled on device rising edges, done/error/ready timing.
// Backpressure: holds data_valid high across a transaction and checks single acceptance afterwards.
module tb_ps2_transmitter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       dev_clk = 1'b1;
    logic       dev_dat = 1'b1;
    logic       ps2_clk;
    logic       ps2_dat;
    logic       clk_oe;
    logic       data_oe;
    logic [7:0] data_i = 8'h00;
    logic       data_valid = 1'b0;
    logic       ready;
    logic       busy;
    logic       done;
    logic       error;

    int checks = 0;
    int failures = 0;
    logic [10:0] fr;

    always #5 clk = ~clk;

    // Wired-AND open-drain bus: either side may pull a line low.
    assign ps2_clk = dev_clk & ~clk_oe;
    assign ps2_dat = dev_dat & ~data_oe;

    ps2_transmitter #(
        .INHIBIT_CYCLES(8),
        .TIMEOUT_CYCLES(64)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .ps2_clk_i    (ps2_clk),
        .ps2_data_i   (ps2_dat),
        .ps2_clk_oe_o (clk_oe),
        .ps2_data_oe_o(data_oe),
        .data_i       (data_i),
        .data_valid_i (data_valid),
        .ready_o      (ready),
        .busy_o       (busy),
        .done_o       (done),
        .error_o      (error)
    );

    typedef struct {
        logic [7:0] dat;
        logic       ack;
        int         low_tail;
        logic       par;
        logic       err;
    } vec_t;

    vec_t vec[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        int n = 0;
        while (!ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("ready_before_send", ready, 1);
        data_i     = b;
        data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
    endtask

    // Device side of one full frame: measures the inhibit, clocks 11 edges,
    // samples on each rising edge, drives ACK level for the 11th edge.
    task automatic run_device(input logic ack, input int low_tail, output logic [10:0] f);
        int n = 0;
        int inh = 0;
        int dcnt = 0;
        logic last_d = 1'b0;
        logic early = 1'b0;
        f = '1;
        while (!clk_oe && n < 50) begin
            @(negedge clk);
            n++;
        end
        while (clk_oe && inh < 100) begin
            if (data_oe) dcnt++;
            last_d = data_oe;
            @(negedge clk);
            inh++;
        end
        chk("inhibit_len", inh, 8);
        chk("start_before_release", last_d, 1);
        chk("data_low_inhibit_cycles", dcnt, 1);
        repeat (3) @(negedge clk);
        f[0] = ps2_dat;
        for (int k = 1; k <= 10; k++) begin
            dev_clk = 1'b0;
            repeat (4) @(negedge clk);
            dev_clk = 1'b1;
            f[k] = ps2_dat;
            repeat (4) @(negedge clk);
        end
        dev_dat = ack;
        @(negedge clk);
        dev_clk = 1'b0;
        for (int k = 0; k < low_tail; k++) begin
            @(negedge clk);
            if (done) early = 1'b1;
        end
        chk("no_done_while_clk_low", early, 0);
        dev_clk = 1'b1;
        dev_dat = 1'b1;
    endtask

    task automatic finish_txn(input logic exp_err);
        int n = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", done, 1);
        chk("error", error, exp_err);
        chk("oe_released_at_done", {clk_oe, data_oe}, 0);
        chk("ready_low_with_done", ready, 0);
        @(negedge clk);
        chk("ready_after_done", ready, 1);
        chk("done_single_pulse", done, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int cnt;
        logic flag;

        //              dat    ack  tail par  err
        vec[0] = '{8'hED, 1'b0, 4,  1'b1, 1'b0};
        vec[1] = '{8'h02, 1'b0, 4,  1'b0, 1'b0};
        vec[2] = '{8'hFF, 1'b1, 4,  1'b1, 1'b1};   // NACK
        vec[3] = '{8'hF4, 1'b0, 20, 1'b0, 1'b0};   // slow idle after ACK
        vec[4] = '{8'h00, 1'b0, 4,  1'b1, 1'b0};

        repeat (2) @(negedge clk);
        chk("rst_ready", ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done_error", {done, error}, 0);
        chk("rst_oe", {clk_oe, data_oe}, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            send(vec[i].dat);
            run_device(vec[i].ack, vec[i].low_tail, fr);
            chk("start_bit", fr[0], 0);
            chk("data_bits", fr[8:1], vec[i].dat);
            chk("parity_bit", fr[9], vec[i].par);
            chk("stop_bit", fr[10], 1);
            finish_txn(vec[i].err);
            repeat (3) @(negedge clk);
        end

        // Backpressure: 0x55 held valid through an 0xF4 transaction.
        send(8'hF4);
        data_i     = 8'h55;
        data_valid = 1'b1;
        run_device(1'b0, 4, fr);
        chk("bp_first_frame", fr[8:1], 8'hF4);
        finish_txn(1'b0);
        @(negedge clk);
        data_valid = 1'b0;
        run_device(1'b0, 4, fr);
        chk("bp_second_frame", fr[8:1], 8'h55);
        chk("bp_second_parity", fr[9], 1);
        finish_txn(1'b0);
        flag = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (clk_oe || !ready) flag = 1'b1;
        end
        chk("bp_accepted_once", flag, 0);

        // Timeout: device never clocks after the start bit.
        send(8'hA5);
        n = 0;
        while (clk_oe && n < 100) begin
            @(negedge clk);
            n++;
        end
        cnt = 0;
        n = 0;
        while (!done && n < 200) begin
            if (!clk_oe && data_oe) cnt++;
            @(negedge clk);
            n++;
        end
        chk("timeout_start_cycles", cnt, 64);
        finish_txn(1'b1);
        repeat (3) @(negedge clk);

        // Reset mid-DATA: after the 4th falling edge bit 3 of 0x33 (0) is driven.
        send(8'h33);
        n = 0;
        while (clk_oe && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            dev_clk = 1'b0;
            repeat (4) @(negedge clk);
            dev_clk = 1'b1;
            repeat (4) @(negedge clk);
        end
        dev_clk = 1'b0;
        repeat (2) @(negedge clk);
        chk("pre_reset_data_oe", data_oe, 1);
        chk("pre_reset_busy", busy, 1);
        rst = 1'b1;
        #1;
        chk("rst_mid_oe_released", {clk_oe, data_oe}, 0);
        chk("rst_mid_ready", ready, 1);
        chk("rst_mid_done", done, 0);
        @(negedge clk);
        rst = 1'b0;
        dev_clk = 1'b1;
        flag = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (done || clk_oe || data_oe) flag = 1'b1;
        end
        chk("rst_mid_quiet_after", flag, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ps2_transmitter.md
Name: ps2_transmitter

Overview:
Host-to-device PS/2 transmitter. It sends command bytes to the keyboard, for example 0xED plus a mask for the LEDs, 0xFF for reset, or 0xF4 to enable scanning. It sits beside ps2_receiver inside the PS/2 controller and shares the same filtered ps2_clk/ps2_data inputs. It drives the open-drain lines through active-high pull-low enables and reports completion and errors.

Parameters:
INHIBIT_CYCLES, 10000, number of clk_i cycles the host holds PS/2 clock low before the start bit (≥100 µs; the default is 100 µs at 100 MHz).
TIMEOUT_CYCLES, 200000, maximum clk_i cycles allowed between consecutive device clock falling edges, or spent waiting for the bus to go idle, before aborting.

Ports:
clk_i  in  1  system clock.
rst_i  in  1  reset, asynchronous, active-high.
ps2_clk_i  in  1  filtered PS/2 clock line level.
ps2_data_i  in  1  filtered PS/2 data line level.
ps2_clk_oe_o  out  1  1 = pull PS/2 clock low; 0 = release (high-Z).
ps2_data_oe_o  out  1  1 = pull PS/2 data low; 0 = release.
data_i  in  8  command byte to send.
data_valid_i  in  1  data_i valid.
ready_o  out  1  transmitter idle; accepts a byte.
busy_o  out  1  transaction in progress; the receiver discards frames while high.
done_o  out  1  one-cycle pulse at the end of every accepted transaction.
error_o  out  1  qualifies done_o: 1 = NACK or timeout, 0 = device acknowledged.

Behaviour:
- Reset values: all outputs 0 except ready_o=1. The state is IDLE, the falling-edge history register is 1, and the counters are 0. Reset mid-transaction immediately releases both lines and produces no done_o pulse.
- Falling edge detection: clk_fall = prev_clk & ~ps2_clk_i, where prev_clk is a register of ps2_clk_i.
- Acceptance: a byte is accepted in a cycle where data_valid_i & ready_o. On acceptance:
  - latch the byte;
  - compute parity = ~^data_i (odd parity);
  - the next cycle, ready_o=0, busy_o=1, state INHIBIT.
- busy_o = ~ready_o.
- IDLE: both oe outputs are 0.
- INHIBIT:
  - clk_oe=1 for exactly INHIBIT_CYCLES cycles.
  - On the final cycle, data_oe is also set (start bit 0), so data goes low before clock is released.
  - Then go to START.
- START:
  - clk_oe=0, data_oe=1.
  - Wait for clk_fall.
  - On clk_fall, drive data bit 0 (data_oe = ~bit) and go to DATA with bit index 1.
- DATA:
  - On each clk_fall, drive the next bit, LSB first.
  - After bit 7 has been driven, the next clk_fall drives parity and moves to PARITY.
- PARITY: on clk_fall, release data (stop bit 1, data_oe=0) and go to STOP.
- STOP: on clk_fall (11th edge), sample ps2_data_i as ACK (0 = acknowledged), register it, and go to WAIT_IDLE.
- WAIT_IDLE:
  - Wait until ps2_clk_i=1 and ps2_data_i=1 in the same cycle.
  - Then pulse done_o with error_o = sampled ACK bit, and return to IDLE (ready_o=1 the following cycle).
- Timeout:
  - A counter runs in START, DATA, PARITY, STOP and WAIT_IDLE; it clears on every clk_fall and on every state entry.
  - Reaching TIMEOUT_CYCLES releases both lines, pulses done_o and error_o together, and returns to IDLE.
- data_oe changes only on clk_fall or on state entry as described. Data is never changed while the device clock is high.
- data_valid_i while busy is ignored; no queueing.
- done_o and ready_o are never high in the same cycle.

Test Plan:
- Send 0xED (INHIBIT_CYCLES=8, TIMEOUT_CYCLES=64, bench models the device): clk_oe high for exactly 8 cycles; device samples on rising edges 0,1,0,1,1,0,1,1,1,1 (start, LSB-first data, parity=1), then stop=1; device ACK=0 → done_o=1, error_o=0, ready_o=1 the next cycle.
- Send 0x02: sampled bits are start 0, data 0,1,0,0,0,0,0,0, parity 0, stop 1 → done_o with error_o=0.
- NACK: device holds data high on the 11th clock while sending 0xFF (parity 1) → done_o=1, error_o=1, lines released.
- Timeout: device never clocks after the start bit → after 64 cycles in START, both oe outputs are 0, done_o=error_o=1, state IDLE.
- Backpressure and reset: data_valid_i=1 with 0x55 held during a transaction is ignored until ready_o=1, then accepted exactly once; asserting rst_i mid-DATA releases lines in the same cycle, leaves done_o=0, and sets ready_o=1.
- Slow idle: device keeps clock low 20 cycles after ACK → done_o is asserted only after both lines read high, with no timeout.
